// File: rtl/axi_wr_burst_pkg.sv
// rtl/axi_wr_burst_pkg.sv - shared constants, FSM states and burst helpers for axi_wr_burst
package axi_wr_burst_pkg;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam int         BEAT_BYTES    = 64;
  // Beat counter width: ceil((2^32 - 1) / 64) = 2^26 needs 27 bits.
  localparam int         BEATS_W       = 27;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_DRAIN,
    ST_FIN
  } state_t;

  // Number of 64-byte beats needed to carry len bytes (rounded up).
  function automatic logic [BEATS_W-1:0] page_beats(input logic [31:0] len);
    return {1'b0, len[31:6]} + BEATS_W'(|len[5:0]);
  endfunction

  // AXI awlen for the next burst: min(burst_beats, beats_left) - 1.
  function automatic logic [7:0] calc_awlen(input logic [BEATS_W-1:0] beats_left,
                                            input int burst_beats);
    if (beats_left >= BEATS_W'(burst_beats)) return 8'(burst_beats - 1);
    return 8'(beats_left - BEATS_W'(1));
  endfunction

  // Byte strobe for the final beat of a page; tail == 0 means a full beat.
  function automatic logic [63:0] tail_strb(input logic [5:0] tail);
    if (tail == 6'd0) return {64{1'b1}};
    return (64'd1 << tail) - 64'd1;
  endfunction

endpackage

// File: rtl/axi_skid_buf.sv
// rtl/axi_skid_buf.sv - two-entry valid/ready register slice with registered s_tready
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   s_tdata/s_tvalid/s_tready       upstream side; s_tready is a flop output
//   m_tdata/m_tvalid/m_tready       downstream side; m_tdata/m_tvalid are flop outputs
module axi_skid_buf #(
  parameter int WIDTH = 577
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             out_free;
  logic             s_fire;

  // Upstream may push whenever the skid slot is empty; a beat accepted while
  // the output is stalled parks in the skid slot, so ready never needs m_tready.
  assign s_tready = ~skid_valid;
  assign s_fire   = s_tvalid & s_tready;
  assign out_free = ~m_tvalid | m_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        m_tdata    <= skid_data;
        m_tvalid   <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        m_tvalid <= s_fire;
        if (s_fire) m_tdata <= s_tdata;
      end
    end else if (s_fire) begin
      skid_data  <= s_tdata;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/axi_wr_burst.sv
// rtl/axi_wr_burst.sv - splits a page beat stream into AXI4 write bursts and tracks responses
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   start, dest_addr, total_len         page request (sampled only in IDLE)
//   in_data/in_valid/in_last/in_ready   512-bit beat stream from the page buffer
//   m_aw*, m_w*, m_b*                   AXI4 write master channels
//   done, err, busy                     page complete pulse, sticky error, not-idle
module axi_wr_burst
  import axi_wr_burst_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int BURST_BEATS = 64,
  parameter int MAX_OUT     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [31:0]       total_len,
  input  logic [511:0]      in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [7:0]        m_awlen,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [511:0]      m_wdata,
  output logic [63:0]       m_wstrb,
  output logic              m_wlast,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic              done,
  output logic              err,
  output logic              busy
);

  localparam int OCW = $clog2(MAX_OUT + 1);
  localparam int SKW = 512 + 64 + 1;

  state_t             state, state_nx;
  logic [BEATS_W-1:0] start_beats;
  logic [BEATS_W-1:0] beats_left;   // page beats not yet handed to the W channel
  logic [BEATS_W-1:0] in_left;      // page beats not yet taken from upstream
  logic [8:0]         beat_cnt;     // W-side beats left in the current burst
  logic [8:0]         in_cnt;       // input-side beats left in the current burst
  logic [5:0]         tail;
  logic [ADDR_W-1:0]  addr;
  logic [OCW-1:0]     out_cnt;
  logic               aw_hs, w_hs, b_count;
  logic               sk_ready, in_fire, calc_last;
  logic [63:0]        in_strb;

  assign start_beats = page_beats(total_len);
  assign aw_hs       = m_awvalid & m_awready;
  assign w_hs        = m_wvalid & m_wready;
  // B beats seen in IDLE are leftovers from an abandoned page: accept and drop.
  assign b_count     = m_bvalid & m_bready & (state != ST_IDLE) & (out_cnt != '0);
  assign busy        = (state != ST_IDLE);

  // wlast and the strobe are decided on the input side because the beat then
  // spends a cycle in the slice; both travel with the data.
  assign in_ready  = sk_ready & (state == ST_W) & (in_cnt != 9'd0);
  assign in_fire   = in_valid & in_ready;
  assign calc_last = (in_cnt == 9'd1);
  assign in_strb   = (in_left == BEATS_W'(1)) ? tail_strb(tail) : {64{1'b1}};

  axi_skid_buf #(.WIDTH(SKW)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  ({in_data, in_strb, calc_last}),
    .s_tvalid (in_fire),
    .s_tready (sk_ready),
    .m_tdata  ({m_wdata, m_wstrb, m_wlast}),
    .m_tvalid (m_wvalid),
    .m_tready (m_wready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = (start_beats != '0) ? ST_AW : ST_FIN;
      ST_AW:    if (aw_hs) state_nx = ST_W;
      ST_W:     if (w_hs && beat_cnt == 9'd1)
                  state_nx = (beats_left != BEATS_W'(1)) ? ST_AW : ST_DRAIN;
      // Look at the count after this cycle's B so done follows the last B by one edge.
      ST_DRAIN: if (out_cnt == '0 || (out_cnt == OCW'(1) && b_count)) state_nx = ST_FIN;
      ST_FIN:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_left <= '0;
      in_left    <= '0;
      beat_cnt   <= '0;
      in_cnt     <= '0;
      tail       <= '0;
      addr       <= '0;
      out_cnt    <= '0;
      m_awvalid  <= 1'b0;
      m_awaddr   <= '0;
      m_awlen    <= '0;
      m_bready   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      // bready stays low only through reset, then is permanently high.
      m_bready <= 1'b1;
      done     <= (state == ST_FIN);

      if (state == ST_IDLE && start) begin
        beats_left <= start_beats;
        in_left    <= start_beats;
        tail       <= total_len[5:0];
        addr       <= dest_addr;
        out_cnt    <= '0;
        err        <= 1'b0;
      end else begin
        if (b_count && m_bresp != AXI_RESP_OKAY) err <= 1'b1;
        if (in_fire && in_last != calc_last)     err <= 1'b1;
        case ({aw_hs, b_count})
          2'b10:   out_cnt <= out_cnt + OCW'(1);
          2'b01:   out_cnt <= out_cnt - OCW'(1);
          default: out_cnt <= out_cnt;
        endcase
      end

      // awvalid is raised one cycle into AW, and only while a response slot is free;
      // once up it holds until accepted, since out_cnt can only fall meanwhile.
      if (state == ST_AW && !m_awvalid && out_cnt != OCW'(MAX_OUT)) begin
        m_awvalid <= 1'b1;
        m_awaddr  <= addr;
        m_awlen   <= calc_awlen(beats_left, BURST_BEATS);
      end else if (aw_hs) begin
        m_awvalid <= 1'b0;
        addr      <= addr + ADDR_W'({({1'b0, m_awlen} + 9'd1), 6'b0});
        beat_cnt  <= {1'b0, m_awlen} + 9'd1;
        in_cnt    <= {1'b0, m_awlen} + 9'd1;
      end

      if (w_hs) begin
        beat_cnt   <= beat_cnt - 9'd1;
        beats_left <= beats_left - BEATS_W'(1);
      end
      if (in_fire) begin
        in_cnt  <= in_cnt - 9'd1;
        in_left <= in_left - BEATS_W'(1);
      end
    end
  end

endmodule
